// File: rtl/serial_loader.sv
// UART (8N1) boot loader: receives a word count then little-endian words and writes them to data memory.
// Stop-bit sample -> byte valid 1 cycle; 4th byte valid -> MemWrite 1 cycle; last MemWrite -> done 2 cycles.
`timescale 1ns/1ps
module serial_loader #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        MemWrite,
  output logic [31:0] address,
  output logic [31:0] writeData,
  output logic        busy,
  output logic        done,
  output logic        frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] L_IDLE  = 2'd0;
  localparam logic [1:0] L_DATA  = 2'd1;
  localparam logic [1:0] L_WRITE = 2'd2;
  localparam logic [1:0] L_DONE  = 2'd3;

  logic          rx_s1_q, rx_s2_q;
  logic [1:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_vld_q, rx_vld_d;
  logic          rx_ferr_q, rx_ferr_d;

  logic [1:0]  ld_state_q, ld_state_d;
  logic [7:0]  idx_q, idx_d;
  logic [8:0]  rem_q, rem_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] word_q, word_d;
  logic        mw_q, mw_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;

  // Receiver: all decisions use the synchronized line rx_s2_q.
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_vld_d   = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          rx_state_d = RX_START;
          cnt_d      = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d      = '0;
          bit_d      = 3'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (cnt_q == FULL_M1) begin
          rx_state_d = RX_IDLE;
          rx_vld_d   = rx_s2_q;
          rx_ferr_d  = !rx_s2_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // Loader: received byte stays in shift_q while rx_vld_q is high.
  always_comb begin
    ld_state_d = ld_state_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    mw_d       = 1'b0;
    addr_d     = addr_q;
    wd_d       = wd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ferr_d     = ferr_q | rx_ferr_q;
    case (ld_state_q)
      L_IDLE: begin
        if (rx_vld_q) begin
          rem_d      = (shift_q == 8'd0) ? 9'd256 : {1'b0, shift_q};
          idx_d      = 8'd0;
          bcnt_d     = 2'd0;
          busy_d     = 1'b1;
          ferr_d     = 1'b0;
          ld_state_d = L_DATA;
        end
      end
      L_DATA: begin
        if (rx_ferr_q) begin
          busy_d     = 1'b0;
          ld_state_d = L_IDLE;
        end else if (rx_vld_q) begin
          word_d[bcnt_q*8 +: 8] = shift_q;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            mw_d       = 1'b1;
            addr_d     = {22'b0, idx_q, 2'b00};
            wd_d       = {shift_q, word_q[23:0]};
            ld_state_d = L_WRITE;
          end
        end
      end
      L_WRITE: begin
        idx_d      = idx_q + 8'd1;
        rem_d      = rem_q - 9'd1;
        ld_state_d = (rem_q == 9'd1) ? L_DONE : L_DATA;
      end
      default: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        ld_state_d = L_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      rx_vld_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      ld_state_q <= L_IDLE;
      idx_q      <= 8'd0;
      rem_q      <= 9'd0;
      bcnt_q     <= 2'd0;
      word_q     <= 32'd0;
      mw_q       <= 1'b0;
      addr_q     <= 32'd0;
      wd_q       <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_vld_q   <= rx_vld_d;
      rx_ferr_q  <= rx_ferr_d;
      ld_state_q <= ld_state_d;
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      mw_q       <= mw_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  assign MemWrite  = mw_q;
  assign address   = addr_q;
  assign writeData = wd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader: drives UART frames and checks the memory write stream.
`timescale 1ns/1ps
module tb_serial_loader;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        MemWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        busy;
  logic        done;
  logic        frame_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .MemWrite(MemWrite), .address(address),
    .writeData(writeData), .busy(busy), .done(done), .frame_err(frame_err)
  );

  // Write/done log captured on the falling edge.
  int          cyc = 0, wr_n = 0, done_n = 0, wide_n = 0, last_wr_cyc = 0, done_cyc = 0;
  logic [31:0] wr_addr [512];
  logic [31:0] wr_data [512];
  logic        prev_mw = 1'b0;
  logic        busy_at_done = 1'b1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (MemWrite) begin
      if (prev_mw) wide_n = wide_n + 1;
      wr_addr[wr_n] = address;
      wr_data[wr_n] = writeData;
      wr_n = wr_n + 1;
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_n = done_n + 1;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    prev_mw = MemWrite;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mw"},   32'(MemWrite),  32'd0);
    chk({tag, "_addr"}, address,        32'd0);
    chk({tag, "_wd"},   writeData,      32'd0);
    chk({tag, "_busy"}, 32'(busy),      32'd0);
    chk({tag, "_done"}, 32'(done),      32'd0);
    chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    int base, d0;
    logic [7:0] bb;
    logic [31:0] exp_w;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single word load
    base = wr_n; d0 = done_n;
    send_byte(8'h01, 1'b1);
    repeat (2) @(negedge clk);
    chk("t1_busy_hi", 32'(busy), 32'd1);
    send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
    settle();
    chk("t1_nwr", 32'(wr_n - base), 32'd1);
    chk("t1_addr", wr_addr[base], 32'h0);
    chk("t1_data", wr_data[base], 32'h12345678);
    chk("t1_ndone", 32'(done_n - d0), 32'd1);
    chk("t1_done_lat", 32'(done_cyc - last_wr_cyc), 32'd2);
    chk("t1_busy_at_done", 32'(busy_at_done), 32'd0);
    chk("t1_busy_lo", 32'(busy), 32'd0);
    chk("t1_ferr", 32'(frame_err), 32'd0);

    // Three words, bytes 0x01..0x0C
    base = wr_n; d0 = done_n;
    send_byte(8'h03, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      bb = 8'(i);
      send_byte(bb, 1'b1);
    end
    settle();
    chk("t2_nwr", 32'(wr_n - base), 32'd3);
    chk("t2_addr0", wr_addr[base],     32'h0);
    chk("t2_addr1", wr_addr[base + 1], 32'h4);
    chk("t2_addr2", wr_addr[base + 2], 32'h8);
    chk("t2_data0", wr_data[base],     32'h04030201);
    chk("t2_data1", wr_data[base + 1], 32'h08070605);
    chk("t2_data2", wr_data[base + 2], 32'h0C0B0A09);
    chk("t2_wide", 32'(wide_n), 32'd0);
    chk("t2_ndone", 32'(done_n - d0), 32'd1);

    // N=0 -> 256 words, byte stream 0x00,0x01,... modulo 256
    base = wr_n; d0 = done_n;
    send_byte(8'h00, 1'b1);
    for (int j = 0; j < 1024; j++) begin
      bb = 8'(j);
      send_byte(bb, 1'b1);
    end
    settle();
    chk("t3_nwr", 32'(wr_n - base), 32'd256);
    for (int k = 0; k < 256; k++) begin
      exp_w = {8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1), 8'(4*k)};
      chk($sformatf("t3_addr%0d", k), wr_addr[base + k], 32'(4*k));
      chk($sformatf("t3_data%0d", k), wr_data[base + k], exp_w);
    end
    chk("t3_wide", 32'(wide_n), 32'd0);
    chk("t3_ndone", 32'(done_n - d0), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);

    // Framing error mid-load, then recovery
    base = wr_n; d0 = done_n;
    send_byte(8'h02, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bb = 8'hA0 + 8'(i);
      send_byte(bb, 1'b1);
    end
    send_byte(8'h55, 1'b0);
    settle();
    chk("t4_nwr", 32'(wr_n - base), 32'd1);
    chk("t4_addr", wr_addr[base], 32'h0);
    chk("t4_data", wr_data[base], 32'hA3A2A1A0);
    chk("t4_hold_wd", writeData, 32'hA3A2A1A0);
    chk("t4_ferr", 32'(frame_err), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_ndone", 32'(done_n - d0), 32'd0);
    send_byte(8'h01, 1'b1);
    repeat (2) @(negedge clk);
    chk("t4_ferr_clr", 32'(frame_err), 32'd0);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    settle();
    chk("t4_nwr2", 32'(wr_n - base), 32'd2);
    chk("t4_addr2", wr_addr[base + 1], 32'h0);
    chk("t4_data2", wr_data[base + 1], 32'h44332211);
    chk("t4_ndone2", 32'(done_n - d0), 32'd1);

    // Short low glitch must not start a byte
    base = wr_n;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("t5_glitch_busy", 32'(busy), 32'd0);
    chk("t5_glitch_ferr", 32'(frame_err), 32'd0);
    chk("t5_glitch_nwr", 32'(wr_n - base), 32'd0);

    // Asynchronous reset in the middle of a load
    send_byte(8'h02, 1'b1);
    for (int i = 0; i < 6; i++) begin
      bb = 8'hB0 + 8'(i);
      send_byte(bb, 1'b1);
    end
    chk("t5_pre_busy", 32'(busy), 32'd1);
    chk("t5_pre_wd", writeData, 32'hB3B2B1B0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t5_async");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    base = wr_n; d0 = done_n;
    send_byte(8'h01, 1'b1);
    send_byte(8'hC0, 1'b1); send_byte(8'hC1, 1'b1);
    send_byte(8'hC2, 1'b1); send_byte(8'hC3, 1'b1);
    settle();
    chk("t5_nwr", 32'(wr_n - base), 32'd1);
    chk("t5_addr", wr_addr[base], 32'h0);
    chk("t5_data", wr_data[base], 32'hC3C2C1C0);
    chk("t5_ndone", 32'(done_n - d0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
